// File: rtl/cp0_intr_ctrl.sv
// Coprocessor-0 register file and external interrupt sequencer.
// Redirects the PC to the handler on a take and back to EPC on ERET.
module cp0_intr_ctrl #(
  parameter logic [31:0] HANDLER_RESET = 32'h0000_0100,
  parameter bit          INT_SYNC      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [31:0] data_w,
  input  logic [31:0] ret_addr,
  input  logic        ir_in,
  output logic        jump_en,
  output logic [31:0] jump_addr,
  output logic        flush,
  output logic        int_ack
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MTC0 = 2'b10;
  localparam logic [1:0] OP_ERET = 2'b11;

  localparam logic [4:0] R_STATUS = 5'd12;
  localparam logic [4:0] R_EPC    = 5'd14;
  localparam logic [4:0] R_EHB    = 5'd15;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    ISR,
    RET
  } state_t;

  state_t      state;
  logic        ie;
  logic [31:0] epc;
  logic [31:0] ehb;
  logic        pending;
  logic        ir_s;
  logic        ir_prev;
  logic        rise;
  logic        mtc0_we;
  logic        eret;
  logic        take;

  generate
    if (INT_SYNC) begin : g_sync
      logic sync1;
      logic sync2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
        end else begin
          sync1 <= ir_in;
          sync2 <= sync1;
        end
      end
      assign ir_s = sync2;
    end else begin : g_nosync
      assign ir_s = ir_in;
    end
  endgenerate

  assign rise = ir_s & ~ir_prev;
  assign eret = en & (oper == OP_ERET);

  // TAKE/RET cycles carry an instruction being flushed.
  assign mtc0_we = en & (oper == OP_MTC0)
                 & ((state == IDLE) | (state == ISR));

  assign take = (state == IDLE) & pending & ie
              & en & (oper == OP_NONE);

  always_comb begin
    data_r = '0;
    unique case (1'b1)
      (addr_r == R_STATUS): data_r = {31'd0, ie};
      (addr_r == R_EPC):    data_r = epc;
      (addr_r == R_EHB):    data_r = ehb;
      default:              data_r = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ie        <= 1'b0;
      epc       <= '0;
      ehb       <= HANDLER_RESET;
      pending   <= 1'b0;
      ir_prev   <= 1'b0;
      jump_en   <= 1'b0;
      jump_addr <= '0;
      flush     <= 1'b0;
      int_ack   <= 1'b0;
    end else begin
      ir_prev   <= ir_s;
      jump_en   <= 1'b0;
      jump_addr <= '0;
      flush     <= 1'b0;
      int_ack   <= 1'b0;
      if (rise) pending <= 1'b1;
      if (mtc0_we) begin
        unique case (1'b1)
          (addr_r == R_STATUS): ie  <= data_w[0];
          (addr_r == R_EPC):    epc <= data_w;
          (addr_r == R_EHB):    ehb <= data_w;
          default: ;
        endcase
      end
      unique case (state)
        IDLE: begin
          if (take) begin
            state     <= TAKE;
            epc       <= ret_addr;
            ie        <= 1'b0;
            pending   <= 1'b0;
            jump_en   <= 1'b1;
            jump_addr <= ehb;
            flush     <= 1'b1;
            int_ack   <= 1'b1;
          end else if (eret) begin
            state     <= RET;
            jump_en   <= 1'b1;
            jump_addr <= epc;
            flush     <= 1'b1;
          end
        end
        TAKE: state <= ISR;
        ISR: begin
          if (eret) begin
            state     <= RET;
            jump_en   <= 1'b1;
            jump_addr <= epc;
            flush     <= 1'b1;
          end
        end
        RET: begin
          ie    <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed bench for cp0_intr_ctrl: expected outputs are queued
// with each stimulus step and popped after the clock edge.
module tb_cp0_intr_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  oper;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic [31:0] data_w;
  logic [31:0] ret_addr;
  logic        ir_in;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        flush;
  logic        int_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [34:0] val;
  } exp_t;

  exp_t q[$];

  cp0_intr_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .oper      (oper),
    .addr_r    (addr_r),
    .data_r    (data_r),
    .data_w    (data_w),
    .ret_addr  (ret_addr),
    .ir_in     (ir_in),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .flush     (flush),
    .int_ack   (int_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string tag, input logic je,
                      input logic [31:0] ja, input logic fl,
                      input logic ack);
    exp_t e;
    e.tag = tag;
    e.val = {je, ja, fl, ack};
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [34:0] got;
    e = q.pop_front();
    got = {jump_en, jump_addr, flush, int_ack};
    checks++;
    assert (got === e.val) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", e.tag, got, e.val);
    end
  endtask

  // Queue the outputs expected after the next edge, then compare.
  task automatic cyc(input string tag, input logic je,
                     input logic [31:0] ja, input logic fl,
                     input logic ack);
    push(tag, je, ja, fl, ack);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [4:0] idx,
                    input logic [31:0] exp);
    addr_r = idx;
    #1;
    checks++;
    assert (data_r === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, data_r, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    oper     = 2'b00;
    addr_r   = 5'd0;
    data_w   = 32'd0;
    ret_addr = 32'd0;
    ir_in    = 1'b0;

    // reset state
    #12;
    push("reset_out", 1'b0, 32'd0, 1'b0, 1'b0);
    pop_check();
    rd("reset_status", 5'd12, 32'd0);
    rd("reset_ehb", 5'd15, 32'h100);
    rd("reset_epc", 5'd14, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // unmapped index ignores writes
    en = 1'b1; oper = 2'b10; addr_r = 5'd3; data_w = 32'hdead;
    idle("mtc0_r3", 1);
    rd("r3_zero", 5'd3, 32'd0);

    // enable IE, then take a pulsed interrupt
    addr_r = 5'd12; data_w = 32'd1;
    rd("no_bypass", 5'd12, 32'd0);
    idle("mtc0_ie", 1);
    oper = 2'b00; ret_addr = 32'h40;
    rd("ie_set", 5'd12, 32'd1);
    ir_in = 1'b1;
    idle("sync1", 1);
    ir_in = 1'b0;
    idle("sync2", 2);
    cyc("take1", 1'b1, 32'h100, 1'b1, 1'b1);
    rd("epc_40", 5'd14, 32'h40);
    rd("ie_clr", 5'd12, 32'd0);
    idle("isr1", 1);

    // ERET from the handler
    oper = 2'b11;
    cyc("ret1", 1'b1, 32'h40, 1'b1, 1'b0);
    oper = 2'b00;
    idle("idle_after_ret", 1);
    rd("ie_restored", 5'd12, 32'd1);

    // masked request waits until IE is set
    oper = 2'b10; addr_r = 5'd12; data_w = 32'd0;
    idle("mtc0_ie0", 1);
    oper = 2'b00;
    ir_in = 1'b1;
    idle("masked_a", 1);
    ir_in = 1'b0;
    idle("masked_b", 20);
    oper = 2'b10; data_w = 32'd1;
    idle("mtc0_ie1", 1);
    oper = 2'b00; ret_addr = 32'h80;
    cyc("take2", 1'b1, 32'h100, 1'b1, 1'b1);
    idle("isr2", 1);
    rd("epc_80", 5'd14, 32'h80);
    oper = 2'b11;
    cyc("ret2", 1'b1, 32'h80, 1'b1, 1'b0);
    oper = 2'b00;
    idle("idle2", 1);

    // stall holds a pending request; ignored MTC0 while stalled
    en = 1'b0;
    ir_in = 1'b1;
    idle("stall_a", 1);
    ir_in = 1'b0;
    oper = 2'b10; addr_r = 5'd15; data_w = 32'h200;
    idle("stall_b", 7);
    rd("ehb_kept", 5'd15, 32'h100);
    oper = 2'b00; en = 1'b1; ret_addr = 32'hC0;
    cyc("take3", 1'b1, 32'h100, 1'b1, 1'b1);

    // second request arrives during the handler
    ir_in = 1'b1;
    idle("isr3_a", 1);
    ir_in = 1'b0;
    idle("isr3_b", 2);
    oper = 2'b11;
    cyc("ret3", 1'b1, 32'hC0, 1'b1, 1'b0);
    oper = 2'b00; ret_addr = 32'hD0;
    idle("idle3", 1);
    cyc("take4", 1'b1, 32'h100, 1'b1, 1'b1);
    rd("epc_d0", 5'd14, 32'hD0);
    idle("isr4", 1);
    oper = 2'b11;
    cyc("ret4", 1'b1, 32'hD0, 1'b1, 1'b0);
    oper = 2'b00;
    idle("idle4", 1);

    // reset during TAKE
    ir_in = 1'b1;
    idle("rst_a", 1);
    ir_in = 1'b0;
    idle("rst_b", 2);
    cyc("take5", 1'b1, 32'h100, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    push("rst_async", 1'b0, 32'd0, 1'b0, 1'b0);
    pop_check();
    rd("rst_epc", 5'd14, 32'd0);
    rd("rst_status", 5'd12, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle("post_rst", 4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
